// File: rtl/tribus_responder_pkg.sv
// Types for the tri-state bus responder, built on the shared bus encodings.
package tribus_responder_pkg;
  `include "tribus_defs.vh"

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    WACK  = ST_WACK,
    TURN  = ST_TURN,
    DRIVE = ST_DRIVE,
    DONE  = ST_DONE
  } state_t;
endpackage

// File: rtl/tri_drv.sv
// Width-parameterised tri-state buffer: passes i_in when enabled, floats otherwise.
module tri_drv #(
  parameter int W = 8
) (
  input  logic         i_en,
  input  logic [W-1:0] i_in,
  output wire  [W-1:0] o_out
);
  assign o_out = i_en ? i_in : {W{1'bz}};
endmodule

// File: rtl/tribus_defs.vh
// Shared state encodings and default widths for both ends of the tri-state bus.
// Included inside a package or module scope by each side.
localparam logic [2:0] ST_IDLE  = 3'd0;
localparam logic [2:0] ST_WACK  = 3'd1;
localparam logic [2:0] ST_TURN  = 3'd2;
localparam logic [2:0] ST_DRIVE = 3'd3;
localparam logic [2:0] ST_DONE  = 3'd4;
localparam int DEF_DATA_W = 8;
localparam int DEF_ADDR_W = 3;

// File: rtl/tribus_responder.sv
// Target endpoint of the shared tri-state bus: stores writes, answers reads in a
// dedicated drive slot framed by a turnaround cycle and a release cycle.
module tribus_responder
  import tribus_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  inout  wire  [DATA_W-1:0] io_bus_data,
  output logic              o_ack,
  output logic              o_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  state_t              r_state;
  state_t              w_next;
  logic                r_ack;
  logic                r_busy;
  logic                r_oe_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [DATA_W-1:0]   r_rdata_q;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_accept;

  // Request lines are only looked at while idle.
  assign w_accept = (r_state == IDLE) && i_req;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (i_req) w_next = i_wr ? WACK : TURN;
      WACK:    w_next = DONE;
      TURN:    w_next = DRIVE;
      DRIVE:   w_next = DONE;
      DONE:    if (!i_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_oe_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == WACK) || (w_next == DRIVE);
      r_busy  <= (w_next != IDLE);
      r_oe_q  <= (w_next == DRIVE);
    end
  end

  // Writes commit at the accepting edge, so a following read always sees them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr_q  <= '0;
      r_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept && i_wr)  r_mem[i_addr] <= io_bus_data;
      if (w_accept && !i_wr) r_addr_q <= i_addr;
      if (r_state == TURN)   r_rdata_q <= r_mem[r_addr_q];
    end
  end

  tri_drv #(.W(DATA_W)) u_bus_drv (
    .i_en  (r_oe_q),
    .i_in  (r_rdata_q),
    .o_out (io_bus_data)
  );

  assign o_ack  = r_ack;
  assign o_busy = r_busy;
endmodule
